// File: rtl/traffic_sched.sv
// traffic_sched -- three-approach traffic light scheduler.
//
// Cycles CLEAR (all red) -> PREP (red-yellow) -> GREEN -> YELLOW for one
// granted approach at a time. Arbitration on the final CLEAR tick is
// round-robin starting after the previously granted approach. Timing only
// advances on cycles where 'tick' is high.
//
// Optional feature: define TRAFFIC_SCHED_PED_EN to add a pedestrian WALK
// phase (all red, walk=1) inserted after YELLOW when a pedestrian request
// has been latched.
//
// Ports
//   clk50M   in   1  sole clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   tick     in   1  one-cycle timebase pulse
//   req      in   3  level demand per approach (bit n = approach n)
//   ped_req  in   1  pedestrian request pulse (TRAFFIC_SCHED_PED_EN only)
//   tfst     out  6  light code per approach, [2n+1:2n]:
//                    00 red, 11 red-yellow, 10 green, 01 yellow
//   active   out  2  approach currently granted (0..2)
//   phase    out  2  state: 0 CLEAR (also WALK), 1 PREP, 2 GREEN, 3 YELLOW
//   walk     out  1  pedestrian walk lamp (TRAFFIC_SCHED_PED_EN only)

module traffic_sched #(
    parameter int T_CLEAR     = 5,
    parameter int T_PREP      = 2,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 10,
`ifdef TRAFFIC_SCHED_PED_EN
    parameter int T_YELLOW    = 2,
    parameter int T_WALK      = 6
`else
    parameter int T_YELLOW    = 2
`endif
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] req,
`ifdef TRAFFIC_SCHED_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [5:0] tfst,
    output logic [1:0] active,
    output logic [1:0] phase
);

`ifdef TRAFFIC_SCHED_PED_EN
    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_PREP   = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_WALK   = 3'd4
    } state_t;
    localparam logic [3:0] WALK_LAST = 4'(T_WALK - 1);
`else
    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_PREP   = 2'd1,
        S_GREEN  = 2'd2,
        S_YELLOW = 2'd3
    } state_t;
`endif

    localparam logic [3:0] CLEAR_LAST  = 4'(T_CLEAR - 1);
    localparam logic [3:0] PREP_LAST   = 4'(T_PREP - 1);
    localparam logic [3:0] YELLOW_LAST = 4'(T_YELLOW - 1);
    localparam logic [3:0] GREEN_SAT   = 4'(T_MAX_GREEN - 1);
    localparam logic [3:0] MIN_GREEN   = 4'(T_MIN_GREEN);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] active_q, active_d;
    logic [5:0] tfst_q, tfst_d;
    logic [1:0] phase_q, phase_d;
    logic       rst_dly_q;

    logic       tick_ok;
    logic [1:0] rr1, rr2, grant;
    logic [2:0] others;
    logic [3:0] elapsed;
    logic [1:0] code_d;

`ifdef TRAFFIC_SCHED_PED_EN
    logic ped_q, ped_d;
    logic walk_q, walk_d;
    logic ped_set;
    assign ped_set = ped_q | ped_req;
    assign walk    = walk_q;
`endif

    assign tfst   = tfst_q;
    assign active = active_q;
    assign phase  = phase_q;

    // High on the first clock edge after reset release, so a tick on the
    // release cycle is discarded.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) rst_dly_q <= 1'b1;
        else     rst_dly_q <= 1'b0;
    end

    assign tick_ok = tick & ~rst_dly_q;

    // Round-robin candidates after the last grant; falls back to the
    // last grant itself when it is the only requester.
    assign rr1   = (active_q == 2'd2) ? 2'd0 : active_q + 2'd1;
    assign rr2   = (rr1 == 2'd2) ? 2'd0 : rr1 + 2'd1;
    assign grant = req[rr1] ? rr1 : (req[rr2] ? rr2 : active_q);

    assign others  = req & ~(3'b001 << active_q);
    assign elapsed = cnt_q + 4'd1;

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            cnt_q    <= 4'd0;
            active_q <= 2'd2;
            tfst_q   <= 6'd0;
            phase_q  <= 2'd0;
`ifdef TRAFFIC_SCHED_PED_EN
            ped_q    <= 1'b0;
            walk_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            tfst_q   <= tfst_d;
            phase_q  <= phase_d;
`ifdef TRAFFIC_SCHED_PED_EN
            ped_q    <= ped_d;
            walk_q   <= walk_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
`ifdef TRAFFIC_SCHED_PED_EN
        ped_d    = ped_set;
`endif
        if (tick_ok) begin
            case (state_q)
                S_CLEAR: begin
                    // With no demand the counter parks on the last tick and
                    // arbitration repeats on every following tick.
                    if (cnt_q == CLEAR_LAST) begin
                        if (|req) begin
                            state_d  = S_PREP;
                            cnt_d    = 4'd0;
                            active_d = grant;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_PREP: begin
                    if (cnt_q == PREP_LAST) begin
                        state_d = S_GREEN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_GREEN: begin
                    // Max green only applies when contested, and a contested
                    // green always leaves once minimum green is met, so the
                    // minimum test covers both limits. Uncontested green rests
                    // with the counter saturated.
                    if ((|others) && (elapsed >= MIN_GREEN)) begin
                        state_d = S_YELLOW;
                        cnt_d   = 4'd0;
                    end else if (cnt_q != GREEN_SAT) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_YELLOW: begin
                    if (cnt_q == YELLOW_LAST) begin
                        cnt_d   = 4'd0;
`ifdef TRAFFIC_SCHED_PED_EN
                        if (ped_set) begin
                            state_d = S_WALK;
                            ped_d   = 1'b0;
                        end else begin
                            state_d = S_CLEAR;
                        end
`else
                        state_d = S_CLEAR;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef TRAFFIC_SCHED_PED_EN
                S_WALK: begin
                    if (cnt_q == WALK_LAST) begin
                        state_d = S_CLEAR;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`endif
                default: begin
                    state_d = S_CLEAR;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        // Outputs are decoded from next state so they land in registers.
        case (state_d)
            S_PREP:   code_d = 2'b11;
            S_GREEN:  code_d = 2'b10;
            S_YELLOW: code_d = 2'b01;
            default:  code_d = 2'b00;
        endcase
        tfst_d  = {4'b0000, code_d} << {active_d, 1'b0};
        // WALK (code 4) truncates to phase 0.
        phase_d = 2'(state_d);
`ifdef TRAFFIC_SCHED_PED_EN
        walk_d  = (state_d == S_WALK);
`endif
    end

endmodule

// File: tb/tb_traffic_sched.sv
module tb_traffic_sched;

  localparam int T_CLEAR     = 5;
  localparam int T_PREP      = 2;
  localparam int T_MIN_GREEN = 5;
  localparam int T_YELLOW    = 2;
  localparam int T_WALK      = 6;
  localparam logic [10:0] RST_WORD = 11'b0_00_10_000000;

  // clock / reset
  logic       clk50M = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] req = 3'b000;
  logic [5:0] tfst;
  logic [1:0] active;
  logic [1:0] phase;
`ifdef TRAFFIC_SCHED_PED_EN
  logic       ped_req = 1'b0;
  logic       walk;
`endif

  always #10 clk50M = ~clk50M;

  traffic_sched dut (
    .clk50M (clk50M),
    .rst    (rst),
    .tick   (tick),
    .req    (req),
`ifdef TRAFFIC_SCHED_PED_EN
    .ped_req(ped_req),
    .walk   (walk),
`endif
    .tfst   (tfst),
    .active (active),
    .phase  (phase)
  );

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] last_exp;

  // reference model: state 0 CLEAR, 1 PREP, 2 GREEN, 3 YELLOW, 4 WALK
  int m_state;
  int m_el;
  int m_active;
  bit m_ped;

  // observation log for grant order / green length
  int tick_num;
  int prev_phase;
  int cur_green;
  int gq[$];
  int gt[$];
  int glen[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [10:0] obs_word();
    logic w;
`ifdef TRAFFIC_SCHED_PED_EN
    w = walk;
`else
    w = 1'b0;
`endif
    return {w, phase, active, tfst};
  endfunction

  function automatic logic [10:0] model_word();
    logic [1:0] code;
    logic [5:0] t;
    logic [1:0] ph;
    case (m_state)
      1: code = 2'b11;
      2: code = 2'b10;
      3: code = 2'b01;
      default: code = 2'b00;
    endcase
    t = {4'b0000, code} << (2 * m_active);
    ph = (m_state == 4) ? 2'd0 : 2'(m_state);
    return {(m_state == 4), ph, 2'(m_active), t};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_el = 0;
    m_active = 2;
    m_ped = 1'b0;
  endtask

  task automatic model_step();
    int a;
    bit done;
    m_el++;
    case (m_state)
      0: begin
        if (m_el >= T_CLEAR) begin
          m_el = T_CLEAR;
          done = 1'b0;
          for (int k = 1; k <= 3; k++) begin
            a = (m_active + k) % 3;
            if (!done && req[a]) begin
              done = 1'b1;
              m_active = a;
              m_state = 1;
              m_el = 0;
            end
          end
        end
      end
      1: if (m_el == T_PREP) begin m_state = 2; m_el = 0; end
      2: begin
        if (((req & ~(3'b001 << m_active)) != 3'b000) && m_el >= T_MIN_GREEN) begin
          m_state = 3;
          m_el = 0;
        end
      end
      3: begin
        if (m_el == T_YELLOW) begin
          m_el = 0;
          if (m_ped) begin
            m_state = 4;
            m_ped = 1'b0;
          end else begin
            m_state = 0;
          end
        end
      end
      default: if (m_el == T_WALK) begin m_state = 0; m_el = 0; end
    endcase
  endtask

  // driver tasks: every task ends #1 after a rising edge with tick low
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk50M);
        #1;
        check_eq("hold", obs_word(), last_exp);
      end
      tick = 1'b1;
      model_step();
      exp_q.push_back(model_word());
      @(posedge clk50M);
      #1;
      tick = 1'b0;
      last_exp = exp_q.pop_front();
      check_eq("tick", obs_word(), last_exp);
      tick_num++;
      if (phase == 2'd1 && prev_phase == 0) begin
        gq.push_back(int'(active));
        gt.push_back(tick_num);
      end
      if (phase == 2'd2) begin
        cur_green++;
      end else if (prev_phase == 2) begin
        glen.push_back(cur_green);
        cur_green = 0;
      end
      prev_phase = int'(phase);
    end
  endtask

  // Reset asserted between clock edges with ticks pulsed during reset and
  // on the release cycle; none of them may be counted.
  task automatic do_reset();
    @(negedge clk50M);
    rst = 1'b1;
    #1;
    check_eq("rst_async", obs_word(), RST_WORD);
    tick = 1'b1;
    repeat (2) @(posedge clk50M);
    #1;
    rst = 1'b0;
    @(posedge clk50M);
    #1;
    tick = 1'b0;
    check_eq("rst_release", obs_word(), RST_WORD);
    model_reset();
    exp_q.delete();
    last_exp = RST_WORD;
    tick_num = 0;
    prev_phase = 0;
    cur_green = 0;
    gq.delete();
    gt.delete();
    glen.delete();
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};

    do_reset();

    // demand on approach 0 only: clear, prepare, then rest on green
    req = 3'b001;
    run_ticks(30);
    check_eq("rest_phase", phase, 2'd2);
    check_eq("rest_tfst", tfst, 6'b000010);
    check_eq("rest_active", active, 2'd0);

    // competing demand during resting green ends it on the same tick
    req = 3'b100;
    run_ticks(1);
    check_eq("cut_phase", phase, 2'd3);
    check_eq("cut_tfst", tfst, 6'b000001);
    run_ticks(2);
    check_eq("cut_clear", phase, 2'd0);
    run_ticks(5);
    check_eq("cut_grant_phase", phase, 2'd1);
    check_eq("cut_grant_active", active, 2'd2);
    check_eq("cut_grant_tfst", tfst, 6'b110000);

    // no demand: stay all red, then grant on the first demand tick
    do_reset();
    req = 3'b000;
    run_ticks(50);
    check_eq("idle_tfst", tfst, 6'b000000);
    check_eq("idle_phase", phase, 2'd0);
    req = 3'b010;
    run_ticks(1);
    check_eq("late_phase", phase, 2'd1);
    check_eq("late_active", active, 2'd1);
    check_eq("late_tfst", tfst, 6'b001100);
    run_ticks(4);
    check_eq("late_green", phase, 2'd2);

    // reset during green goes straight to all red
    do_reset();

    // full demand: round robin with minimum greens
    req = 3'b111;
    run_ticks(60);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("rr_grant%0d", k), (k < gq.size()) ? gq[k] : 99, exp_order[k]);
    check_eq("rr_cycle_len", (gt.size() >= 4) ? (gt[3] - gt[0]) : -1, 42);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("rr_green_len%0d", k), (k < glen.size()) ? glen[k] : -1, 5);

    // random demand against the model
    for (int i = 0; i < 80; i++) begin
      req = 3'($urandom_range(0, 7));
      run_ticks(1);
    end

`ifdef TRAFFIC_SCHED_PED_EN
    begin
      int walk_cnt;
      do_reset();
      req = 3'b001;
      run_ticks(12);
      ped_req = 1'b1;
      @(posedge clk50M);
      #1;
      ped_req = 1'b0;
      m_ped = 1'b1;
      check_eq("ped_hold", obs_word(), last_exp);
      req = 3'b011;
      walk_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        run_ticks(1);
        if (walk) begin
          walk_cnt++;
          check_eq("walk_tfst", tfst, 6'b000000);
        end
      end
      check_eq("walk_len", walk_cnt, T_WALK);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
